axi_burst_bridge: RTL

AXI_BURST_BRIDGE -- requirements
Module: axi_burst_bridge

---
 rtl/axi_bridge_pkg.sv | 15 +
 rtl/axi_burst_bridge_if.sv | 44 ++++
 rtl/axi_wr_channel.sv | 105 ++++++++++
 rtl/axi_burst_bridge.sv | 130 +++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: FSM state encodings, fixed AXI attribute constants and length clipping
// shared by axi_burst_bridge and axi_wr_channel.
package axi_bridge_pkg;
    typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_B} wr_state_e;
    localparam logic [1:0] AXBURST_INCR  = 2'b01;
    localparam logic [2:0] AXSIZE_4B     = 3'd2;
    localparam logic [2:0] AXSIZE_8B     = 3'd3;
    localparam logic       AXLOCK_NORMAL = 1'b0;
    localparam logic [3:0] AXCACHE_NONE  = 4'd0;
    localparam logic [2:0] AXPROT_NONE   = 3'd0;
    function automatic logic [7:0] clip_len(input logic [7:0] len, input logic [7:0] lim);
        return (len > lim) ? lim : len;
    endfunction
endpackage

// File: rtl/axi_burst_bridge_if.sv
// axi_burst_bridge_if: AXI4 bus between the bridge (master modport) and memory (slave modport).
interface axi_burst_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid, arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast, rvalid, rready;
    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid, awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast, wvalid, wready;
    logic [1:0]          bresp;
    logic                bvalid, bready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_wr_channel.sv
// axi_wr_channel: write FSM (IDLE->AW->W->B) with the beat counter that alone decides wlast.
module axi_wr_channel
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wreq_valid,
    output logic                wreq_ready,
    input  logic [31:0]         wreq_addr,
    input  logic [7:0]          wreq_len,
    input  logic [2:0]          wreq_size,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    input  logic                wd_last,
    output logic                wr_done,
    output logic                busy,
    output logic [19:0]         awpage,
    output logic                len_err_set,
    output logic                b_err,
    axi_burst_bridge_if.master  axi
);
    localparam logic [7:0] LEN_LIM = 8'(MAX_LEN - 1);
    wr_state_e   state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [7:0]  awlen_q, awlen_d, cnt_q, cnt_d;
    logic [2:0]  awsize_q, awsize_d;
    logic        wr_done_q, wr_done_d, beat_last, w_fire;

    assign wreq_ready = state_q == WR_IDLE;
    assign beat_last  = cnt_q == awlen_q;
    assign w_fire     = axi.wvalid && axi.wready;
    assign wd_ready   = state_q == WR_W && axi.wready;
    assign wr_done    = wr_done_q;
    assign busy       = state_q != WR_IDLE;
    assign awpage     = awaddr_q[31:12];
    assign b_err      = state_q == WR_B && axi.bvalid && axi.bresp != 2'b00;

    assign axi.awid    = {ID_W{1'b0}};
    assign axi.awaddr  = awaddr_q;
    assign axi.awlen   = awlen_q;
    assign axi.awsize  = awsize_q;
    assign axi.awburst = AXBURST_INCR;
    assign axi.awlock  = AXLOCK_NORMAL;
    assign axi.awcache = AXCACHE_NONE;
    assign axi.awprot  = AXPROT_NONE;
    assign axi.awvalid = state_q == WR_AW;
    assign axi.wdata   = wd_data;
    assign axi.wstrb   = wd_strb;
    assign axi.wvalid  = state_q == WR_W && wd_valid;
    assign axi.wlast   = state_q == WR_W && beat_last;
    assign axi.bready  = 1'b1;

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        cnt_d       = cnt_q;
        wr_done_d   = 1'b0;
        len_err_set = 1'b0;
        if (wreq_valid && wreq_ready) begin
            state_d     = WR_AW;
            awaddr_d    = wreq_addr;
            awlen_d     = clip_len(wreq_len, LEN_LIM);
            awsize_d    = wreq_size;
            cnt_d       = 8'd0;
            len_err_set = wreq_len > LEN_LIM;
        end
        if (state_q == WR_AW && axi.awready) state_d = WR_W;
        // the counter ends the burst; wd_last only flags disagreement
        if (w_fire) begin
            cnt_d       = cnt_q + 8'd1;
            len_err_set = wd_last != beat_last;
            state_d     = beat_last ? WR_B : state_q;
        end
        if (state_q == WR_B && axi.bvalid) begin
            state_d   = WR_IDLE;
            wr_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= WR_IDLE;
            awaddr_q  <= 32'd0;
            awlen_q   <= 8'd0;
            awsize_q  <= 3'd0;
            cnt_q     <= 8'd0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            cnt_q     <= cnt_d;
            wr_done_q <= wr_done_d;
        end
    end
endmodule

// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: cache-to-AXI4 burst bridge with independent read and write FSMs and a
// 4 KiB page hazard stall on reads. Define AXI_RESP_ERR_EN to add the sticky resp_err output.
module axi_burst_bridge
    import axi_bridge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int MAX_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                rreq_valid,
    output logic                rreq_ready,
    input  logic [31:0]         rreq_addr,
    input  logic [7:0]          rreq_len,
    input  logic [2:0]          rreq_size,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    input  logic                wreq_valid,
    output logic                wreq_ready,
    input  logic [31:0]         wreq_addr,
    input  logic [7:0]          wreq_len,
    input  logic [2:0]          wreq_size,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    input  logic                wd_last,
    output logic                wr_done,
    output logic                len_err,
`ifdef AXI_RESP_ERR_EN
    output logic                resp_err,
`endif
    axi_burst_bridge_if.master  axi
);
    localparam logic [7:0] LEN_LIM = 8'(MAX_LEN - 1);
    rd_state_e   rd_state_q, rd_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        len_err_q, len_err_d, clr, wr_busy, wr_len_err, b_err, hazard;
    logic [19:0] awpage;

    assign clr        = rst || flush;
    assign hazard     = wr_busy && rreq_addr[31:12] == awpage;
    assign rreq_ready = rd_state_q == RD_IDLE && !hazard;
    assign rd_valid   = rd_state_q == RD_R && axi.rvalid;
    assign rd_last    = rd_valid && axi.rlast;
    assign rd_data    = axi.rdata;
    assign len_err    = len_err_q;

    assign axi.arid    = {ID_W{1'b0}};
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arsize  = arsize_q;
    assign axi.arburst = AXBURST_INCR;
    assign axi.arlock  = AXLOCK_NORMAL;
    assign axi.arcache = AXCACHE_NONE;
    assign axi.arprot  = AXPROT_NONE;
    assign axi.arvalid = rd_state_q == RD_AR;
    // rready stays high so beats of a flushed burst drain and are dropped in IDLE
    assign axi.rready  = 1'b1;

    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        len_err_d  = len_err_q || wr_len_err;
        if (rreq_valid && rreq_ready) begin
            rd_state_d = RD_AR;
            araddr_d   = rreq_addr;
            arlen_d    = clip_len(rreq_len, LEN_LIM);
            arsize_d   = rreq_size;
            len_err_d  = len_err_d || rreq_len > LEN_LIM;
        end
        if (rd_state_q == RD_AR && axi.arready) rd_state_d = RD_R;
        if (rd_last) rd_state_d = RD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_state_q <= RD_IDLE;
            araddr_q   <= 32'd0;
            arlen_q    <= 8'd0;
            arsize_q   <= 3'd0;
            len_err_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            len_err_q  <= len_err_d;
        end
    end

    axi_wr_channel #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_LEN(MAX_LEN)) u_wr (
        .clk        (clk),
        .clr        (clr),
        .wreq_valid (wreq_valid),
        .wreq_ready (wreq_ready),
        .wreq_addr  (wreq_addr),
        .wreq_len   (wreq_len),
        .wreq_size  (wreq_size),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .wd_strb    (wd_strb),
        .wd_last    (wd_last),
        .wr_done    (wr_done),
        .busy       (wr_busy),
        .awpage     (awpage),
        .len_err_set(wr_len_err),
        .b_err      (b_err),
        .axi        (axi)
    );

`ifdef AXI_RESP_ERR_EN
    logic resp_err_q, resp_err_d;
    // survives flush on purpose: only rst clears it
    assign resp_err_d = resp_err_q || b_err || (rd_valid && axi.rresp != 2'b00);
    assign resp_err   = resp_err_q;
    always_ff @(posedge clk) resp_err_q <= rst ? 1'b0 : resp_err_d;
`else
    logic unused_resp;
    assign unused_resp = ^{axi.rresp, b_err};
`endif
endmodule
